alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Command buffer and result register wrapped around the combinational Alu.
//  Accepts {A,B,op} commands on a valid/ready input and queues them in a DEPTH-entry FIFO.
//  Presents the FIFO head to the Alu and registers the Alu result on a valid/ready output.
//  Decouples the upstream operand source from the downstream result consumer.
// PARAMETERS
//  W1     4  operand width; must match the Alu's W1. Result width is W1+1.
//  DEPTH  4  command FIFO depth; power of 2, >= 2.
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      upstream command valid
//  in_ready   out  1      stage can accept a command (FIFO not full)
//  in_a       in   W1     operand A
//  in_b       in   W1     operand B
//  in_op      in   2      opcode: 00 add, 01 or, 10 sub, 11 xor
//  alu_a      out  W1     FIFO head A, driven to the Alu
//  alu_b      out  W1     FIFO head B, driven to the Alu
//  alu_op     out  2      FIFO head op, driven to the Alu
//  alu_out    in   W1+1   combinational Alu result for alu_a/alu_b/alu_op
//  res_valid  out  1      registered result valid
//  res_ready  in   1      downstream accepts the result
//  res_data   out  W1+1   registered Alu result
//  res_op     out  2      opcode that produced res_data
//  res_zero   out  1      res_data == 0
//  cmd_count  out  $clog2(DEPTH)+1  number of FIFO entries occupied
// BEHAVIOUR
//  Reset (rst_n=0, async): FIFO empty, pointers 0, cmd_count=0, res_valid=0,
//   res_data=0, res_op=0, res_zero=0. in_ready=1 one cycle after deassertion.
//  push  = in_valid & in_ready, where in_ready = (cmd_count != DEPTH).
//   in_ready does not depend on a same-cycle pop.
//  res_free = !res_valid | res_ready.
//  pop = (cmd_count != 0) & res_free.
//  On pop: res_data<=alu_out, res_op<=alu_op, res_zero<=(alu_out==0), res_valid<=1.
//  Else, if res_ready & res_valid: res_valid<=0, and res_data/res_op/res_zero hold.
//  Empty FIFO: alu_a/alu_b/alu_op = 0.
//  Latency: a command pushed at edge N is popped no earlier than edge N+1.
//   Its result is visible from N+1 (1-cycle minimum); no fall-through path.
//  Throughput: one result per cycle while res_ready=1 and the FIFO is non-empty.
//  Push and pop in the same cycle: cmd_count unchanged. Both pointers advance.
//   Pointers wrap modulo DEPTH.
//  Full: in_ready=0, and commands presented are ignored (not lost: upstream must hold).
//  Backpressure: res_valid=1 & res_ready=0 holds res_* stable and stalls pop.
//  Arithmetic is owned by the Alu: sub wraps modulo 2^(W1+1); add carry lands in bit W1.
//  res_data is never modified by this stage.
//  rst_n asserted mid-stream: all queued commands and any pending result are discarded at once.
//  Upstream hold rule: in_a/in_b/in_op must be stable while in_valid=1 & in_ready=0.
// TESTING (W1=4, DEPTH=4, real Alu instance)
//  Reset, then push add A=F,B=1 with res_ready=1 -> next cycle res_valid=1, res_data=5'h10, res_zero=0.
//  Push sub A=3,B=5 -> res_data=5'h1E, res_op=2'b10.
//   Then push xor A=A,B=A -> res_data=0, res_zero=1.
//  res_ready=0, push 5 commands back-to-back -> 1 in the result register plus 4 queued.
//   in_ready drops on the 5th (cmd_count=4), and the 6th command is held.
//   Release res_ready -> results emerge in order, one per cycle.
//  Continuous push+pop for 10 cycles (pointer wrap) -> cmd_count constant, results in order.
//  Assert rst_n with 3 queued and res_valid=1 -> all outputs reach reset values immediately.
//   No stale result appears after release.
//  Random valid/ready toggling, 1000 commands -> scoreboard vs reference model: no drop, dup or reorder.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Purpose: command FIFO plus registered result stage around an external combinational Alu.
// Latency: 1 cycle minimum, push to result. Backpressure: a stalled result stalls pops and the FIFO fills.

// Purpose: generic synchronous FIFO. The head is presented combinationally and reads as zero when empty.
// Latency: a write at edge N is visible at the head after edge N; there is no fall-through.
// Backpressure: full blocks writes and empty blocks reads; a write and a read together leave count unchanged.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Storage carries no reset; the empty mask hides stale entries.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// Purpose: queue {a,b,op} commands, drive the head to the Alu, and register the Alu result.
// Latency: 1 cycle minimum from push to res_valid; sustains one result per cycle.
// Backpressure: res_valid & !res_ready holds res_* stable and stops pops; in_ready falls when the FIFO is full.
module alu_issue_stage #(
    parameter int W1    = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W1-1:0]          in_a,
    input  logic [W1-1:0]          in_b,
    input  logic [1:0]             in_op,
    output logic [W1-1:0]          alu_a,
    output logic [W1-1:0]          alu_b,
    output logic [1:0]             alu_op,
    input  logic [W1:0]            alu_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [W1:0]            res_data,
    output logic [1:0]             res_op,
    output logic                   res_zero,
    output logic [$clog2(DEPTH):0] cmd_count
);
    typedef struct packed {
        logic [W1-1:0] a;
        logic [W1-1:0] b;
        logic [1:0]    op;
    } cmd_t;

    cmd_t in_cmd;
    cmd_t head;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic res_free;

    assign in_cmd   = '{a: in_a, b: in_b, op: in_op};
    // in_ready depends only on occupancy, never on a same-cycle pop.
    assign in_ready = ~fifo_full;
    assign push     = in_valid & in_ready;
    assign res_free = ~res_valid | res_ready;
    assign pop      = ~fifo_empty & res_free;

    sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (in_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (cmd_count)
    );

    assign alu_a  = head.a;
    assign alu_b  = head.b;
    assign alu_op = head.op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
            res_zero  <= 1'b0;
        end else if (pop) begin
            res_valid <= 1'b1;
            res_data  <= alu_out;
            res_op    <= alu_op;
            res_zero  <= (alu_out == '0);
        end else if (res_ready & res_valid) begin
            res_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and random bench for alu_issue_stage: a queue-based reference model is checked every cycle,
// and hand-computed literal expectations pin that model.
module tb_alu_issue_stage;
    localparam int W1    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W1-1:0] in_a = '0;
    logic [W1-1:0] in_b = '0;
    logic [1:0]    in_op = '0;
    logic [W1-1:0] alu_a;
    logic [W1-1:0] alu_b;
    logic [1:0]    alu_op;
    logic [W1:0]   alu_out;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W1:0]   res_data;
    logic [1:0]    res_op;
    logic          res_zero;
    logic [2:0]    cmd_count;

    always #5 clk = ~clk;

    alu_issue_stage #(.W1(W1), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
        .res_zero  (res_zero),
        .cmd_count (cmd_count)
    );

    // Reference Alu: add, or, sub, xor on W1+1 bits.
    function automatic logic [W1:0] alu_f(input logic [W1-1:0] a, input logic [W1-1:0] b,
                                          input logic [1:0] op);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a | b};
            2'd2:    return {1'b0, a} - {1'b0, b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    always_comb alu_out = alu_f(alu_a, alu_b, alu_op);

    typedef struct packed {
        logic [W1-1:0] a;
        logic [W1-1:0] b;
        logic [1:0]    op;
    } tcmd_t;

    tcmd_t       mq[$];
    logic        m_valid = 1'b0;
    logic [W1:0] m_data = '0;
    logic [1:0]  m_op = '0;
    logic        m_zero = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          started = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_op    = '0;
        m_zero  = 1'b0;
    endtask

    // One clock of the stage's rules: a queue of pending commands and one result slot.
    task automatic model_step();
        bit    do_push;
        bit    do_pop;
        tcmd_t h;
        tcmd_t c;
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = (mq.size() != 0) && (!m_valid || res_ready);
        if (do_pop) begin
            h       = mq.pop_front();
            m_data  = alu_f(h.a, h.b, h.op);
            m_op    = h.op;
            m_zero  = (m_data == 0);
            m_valid = 1'b1;
        end else if (m_valid && res_ready) begin
            m_valid = 1'b0;
        end
        if (do_push) begin
            c.a  = in_a;
            c.b  = in_b;
            c.op = in_op;
            mq.push_back(c);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        if (started && rst_n) begin
            chk("in_ready", in_ready, mq.size() < DEPTH);
            chk("cmd_count", cmd_count, mq.size());
            if (mq.size() != 0) begin
                chk("alu_a", alu_a, mq[0].a);
                chk("alu_b", alu_b, mq[0].b);
                chk("alu_op", alu_op, mq[0].op);
            end else begin
                chk("alu_head_empty", {alu_a, alu_b, alu_op}, 0);
            end
            chk("res_valid", res_valid, m_valid);
            chk("res_data", res_data, m_data);
            chk("res_op", res_op, m_op);
            chk("res_zero", res_zero, m_zero);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_cmd(input bit v, input int a, input int b, input int op);
        in_valid = v;
        in_a     = a[W1-1:0];
        in_b     = b[W1-1:0];
        in_op    = op[1:0];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ta[5];
        int tb[5];
        int top[5];
        int sent;
        int cyc;
        int delivered;
        int drain;
        bit will_push;

        ta  = '{1, 2, 5, 0, 15};
        tb  = '{1, 2, 2, 1, 3};
        top = '{0, 0, 1, 2, 3};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_cmd_count", cmd_count, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_zero", res_zero, 0);
        rst_n   = 1'b1;
        started = 1'b1;
        tick();
        chk("in_ready_after_reset", in_ready, 1);

        // add F+1: carry lands in bit W1, result one cycle after push
        res_ready = 1'b1;
        set_cmd(1, 'hF, 1, 0);
        tick();
        set_cmd(0, 0, 0, 0);
        chk("no_fallthrough_valid", res_valid, 0);
        chk("add_queued", cmd_count, 1);
        tick();
        chk("add_valid", res_valid, 1);
        chk("add_data", res_data, 'h10);
        chk("add_zero", res_zero, 0);

        // sub 3-5 wraps; xor A^A sets zero flag
        set_cmd(1, 3, 5, 2);
        tick();
        set_cmd(0, 0, 0, 0);
        tick();
        chk("sub_data", res_data, 'h1E);
        chk("sub_op", res_op, 2);
        set_cmd(1, 'hA, 'hA, 3);
        tick();
        set_cmd(0, 0, 0, 0);
        tick();
        chk("xor_data", res_data, 0);
        chk("xor_zero", res_zero, 1);
        tick();
        chk("xor_consumed", res_valid, 0);

        // Fill under backpressure: 1 in result register + 4 queued
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_cmd(1, ta[i], tb[i], top[i]);
            tick();
        end
        chk("full_count", cmd_count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_res_data", res_data, 2);
        set_cmd(1, 8, 8, 0);
        tick();
        tick();
        chk("held_count", cmd_count, 4);
        chk("held_res_data", res_data, 2);
        res_ready = 1'b1;
        tick();
        chk("release1_data", res_data, 4);
        chk("release1_count", cmd_count, 3);
        tick();
        chk("release2_data", res_data, 7);
        chk("release2_count", cmd_count, 3);
        set_cmd(0, 0, 0, 0);
        tick();
        chk("release3_data", res_data, 'h1F);
        tick();
        chk("release4_data", res_data, 'hC);
        tick();
        chk("release5_data", res_data, 'h10);
        tick();
        chk("release_done", res_valid, 0);

        // Continuous push+pop across pointer wrap
        set_cmd(1, 1, 2, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            set_cmd(1, i, 3, i % 4);
            tick();
            chk("stream_count", cmd_count, 1);
        end
        chk("stream_last_data", res_data, 'hB);
        set_cmd(0, 0, 0, 0);
        tick();
        tick();
        chk("stream_drained", cmd_count, 0);

        // Reset mid-stream with 3 queued and a pending result
        tick();
        res_ready = 1'b0;
        set_cmd(1, 5, 1, 2);
        tick();
        set_cmd(1, 1, 2, 0);
        tick();
        set_cmd(1, 3, 3, 1);
        tick();
        set_cmd(1, 7, 7, 0);
        tick();
        set_cmd(0, 0, 0, 0);
        chk("pre_rst_count", cmd_count, 3);
        chk("pre_rst_data", res_data, 4);
        chk("pre_rst_op", res_op, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_count", cmd_count, 0);
        chk("mid_rst_data", res_data, 0);
        chk("mid_rst_op", res_op, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        tick();
        rst_n     = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_stale", res_valid, 0);
        end

        // Random valid/ready toggling, 1000 commands
        sent      = 0;
        cyc       = 0;
        delivered = 0;
        while (sent < 1000 && cyc < 20000) begin
            if (!in_valid && $urandom_range(0, 2) != 0) begin
                set_cmd(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 3)));
            end
            res_ready = ($urandom_range(0, 3) != 0);
            will_push = in_valid && in_ready;
            if (res_valid && res_ready) delivered++;
            tick();
            cyc++;
            if (will_push) begin
                sent++;
                if ($urandom_range(0, 1) != 0) begin
                    set_cmd(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                            int'($urandom_range(0, 3)));
                end else begin
                    set_cmd(0, 0, 0, 0);
                end
            end
        end
        chk("random_sent_in_budget", sent, 1000);
        set_cmd(0, 0, 0, 0);
        res_ready = 1'b1;
        drain = 0;
        while ((cmd_count != 0 || res_valid) && drain < 50) begin
            if (res_valid) delivered++;
            tick();
            drain++;
        end
        chk("random_drained", {cmd_count, res_valid}, 0);
        chk("random_delivered", delivered, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
